// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
// The arbiter FSM state encoding is exposed on the top-level state_o debug port.
package obi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/obi_rr_pick.sv
// Combinational requester picker.
// Default: round-robin starting at ptr_i and wrapping at N_REQ-1 -> 0.
// With OBI_ARB_FIXED_PRIO_EN defined: lowest-index set request wins, ptr_i is ignored.
module obi_rr_pick
    import obi_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    logic [IW-1:0] cand_idx;

`ifdef OBI_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Scan from the highest index down so the lowest set request is assigned last and wins.
    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_idx = IW'(i);
            if (req_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
    end
`else
    // Scan offsets from farthest to nearest so the first set request after ptr_i wins.
    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_idx = IW'((int'(ptr_i) + i) % N_REQ);
            if (req_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/obi_rr_arbiter.sv
// Shares one OBI manager port between N_REQ requesters, one transaction at a time.
// FSM IDLE -> ADDR -> RESP -> IDLE; the winner is latched in IDLE, its A-channel is
// forwarded in ADDR, and its R-channel beat is routed back in RESP.
// Handshakes: a beat transfers on a cycle where valid (req/rvalid) and ready (gnt/rready)
// are both high; the arbiter keeps obi_req_o asserted in ADDR until obi_gnt_i arrives.
// Build option: OBI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and drops the
// round-robin pointer.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                    clk_i,
    input  logic                                    reset_ni,
    input  logic [N_REQ-1:0]                        req_i,
    output logic [N_REQ-1:0]                        gnt_o,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]        addr_i,
    input  logic [N_REQ-1:0]                        we_i,
    input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]      be_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]        wdata_i,
    output logic [N_REQ-1:0]                        rvalid_o,
    input  logic [N_REQ-1:0]                        rready_i,
    output logic [DATA_WIDTH-1:0]                   rdata_o,
    output logic                                    err_o,
    output logic                                    obi_req_o,
    input  logic                                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]                   obi_addr_o,
    output logic                                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0]                 obi_be_o,
    output logic [DATA_WIDTH-1:0]                   obi_wdata_o,
    input  logic                                    obi_rvalid_i,
    output logic                                    obi_rready_o,
    input  logic [DATA_WIDTH-1:0]                   obi_rdata_i,
    input  logic                                    obi_err_i,
    output arb_state_e                              state_o
);

    localparam int IW = idx_width(N_REQ);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] sel_next;
    logic [IW-1:0] ptr_cur;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic          ptr_adv;

    assign state_o  = state_q;
    assign sel_next = (sel_q == IW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;

`ifdef OBI_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ptr_adv ^ (^sel_next);
    assign ptr_cur   = '0;
`else
    logic [IW-1:0] ptr_q;
    assign ptr_cur = ptr_q;

    // Round-robin pointer moves past the port that was just granted.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q <= '0;
        end else if (ptr_adv) begin
            ptr_q <= sel_next;
        end
    end
`endif

    obi_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_cur),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State and selected-port registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic and all channel muxing; outputs are zero outside their phase.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_adv      = 1'b0;
        gnt_o        = '0;
        rvalid_o     = '0;
        rdata_o      = '0;
        err_o        = 1'b0;
        obi_req_o    = 1'b0;
        obi_addr_o   = '0;
        obi_we_o     = 1'b0;
        obi_be_o     = '0;
        obi_wdata_o  = '0;
        obi_rready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // Request stays up even if the requester drops req_i; the grant is still forwarded.
                obi_req_o    = 1'b1;
                obi_addr_o   = addr_i[sel_q];
                obi_we_o     = we_i[sel_q];
                obi_be_o     = be_i[sel_q];
                obi_wdata_o  = wdata_i[sel_q];
                gnt_o[sel_q] = obi_gnt_i;
                if (obi_gnt_i) begin
                    ptr_adv = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                obi_rready_o    = rready_i[sel_q];
                rvalid_o[sel_q] = obi_rvalid_i;
                rdata_o         = obi_rdata_i;
                err_o           = obi_err_i;
                if (obi_rvalid_i && rready_i[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Bench for obi_rr_arbiter with four requesters. A table of transactions is applied in
// order; the expected grant vector is queued when a request is driven and compared
// when the manager grant arrives. Hand sequences cover reset during a response.
// Build with OBI_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_obi_rr_arbiter;
    import obi_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

`ifdef OBI_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                   clk_i;
    logic                   reset_ni;
    logic [N-1:0]           req_i;
    logic [N-1:0]           gnt_o;
    logic [N-1:0][AW-1:0]   addr_i;
    logic [N-1:0]           we_i;
    logic [N-1:0][BW-1:0]   be_i;
    logic [N-1:0][DW-1:0]   wdata_i;
    logic [N-1:0]           rvalid_o;
    logic [N-1:0]           rready_i;
    logic [DW-1:0]          rdata_o;
    logic                   err_o;
    logic                   obi_req_o;
    logic                   obi_gnt_i;
    logic [AW-1:0]          obi_addr_o;
    logic                   obi_we_o;
    logic [BW-1:0]          obi_be_o;
    logic [DW-1:0]          obi_wdata_o;
    logic                   obi_rvalid_i;
    logic                   obi_rready_o;
    logic [DW-1:0]          obi_rdata_i;
    logic                   obi_err_i;
    arb_state_e             state_o;

    obi_rr_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rready_o (obi_rready_o),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i),
        .state_o      (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // A requester must not drop its request while the manager has not granted it.
    assert property (@(posedge clk_i) disable iff (!reset_ni)
                     (obi_req_o && !obi_gnt_i) |=> $stable(req_i))
        else begin
            errors++;
            $display("FAIL req_retract req_i=%0h", req_i);
        end

    typedef struct {
        logic [N-1:0]  req;
        int            gnt_wait;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            stall;
        int            exp_rr;
        int            exp_fp;
    } vec_t;

    vec_t tbl[13];

    // ---------------- driver tasks ----------------
    task automatic drive_ports(input int exp_port, input vec_t v);
        for (int p = 0; p < N; p++) begin
            addr_i[p] = 32'h100 + 32'(p) * 32'h10;
            if (p == exp_port) begin
                we_i[p]    = v.we;
                be_i[p]    = v.be;
                wdata_i[p] = v.wdata;
            end else begin
                we_i[p]    = ~v.we;
                be_i[p]    = ~v.be;
                wdata_i[p] = 32'hBAD0_0000 | 32'(p);
            end
        end
    endtask

    task automatic clear_bus();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
        obi_rdata_i  = '0;
        rready_i     = '0;
    endtask

    task automatic run_txn(input vec_t v, input int exp_port);
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  got;
        logic [AW-1:0] exp_addr;
        int            cyc;
        exp_gnt  = 4'b0001 << exp_port;
        exp_addr = 32'h100 + 32'(exp_port) * 32'h10;
        @(negedge clk_i);
        clear_bus();
        drive_ports(exp_port, v);
        req_i = v.req;
        exp_q.push_back(exp_gnt);
        #1;
        chk("idle_no_req", obi_req_o, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk_i);
            #1;
            cyc++;
        end while (!obi_req_o && cyc < 8);
        chk("arb_latency", cyc, 1);
        if (!obi_req_o) begin
            got = exp_q.pop_front();
            return;
        end
        for (int w = 0; w < v.gnt_wait; w++) begin
            chk("wait_req", obi_req_o, 1'b1);
            chk("wait_addr", obi_addr_o, exp_addr);
            chk("wait_wdata", obi_wdata_o, v.wdata);
            chk("wait_gnt_o", gnt_o, '0);
            @(negedge clk_i);
            #1;
        end
        obi_gnt_i = 1'b1;
        #1;
        got = exp_q.pop_front();
        chk("gnt_o", gnt_o, got);
        chk("addr", obi_addr_o, exp_addr);
        chk("we", obi_we_o, v.we);
        chk("be", obi_be_o, v.be);
        chk("wdata", obi_wdata_o, v.wdata);
        @(negedge clk_i);
        obi_gnt_i = 1'b0;
        #1;
        chk("state_resp", state_o, RESP);
        chk("resp_no_early_rvalid", rvalid_o, '0);
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = v.rdata;
        obi_err_i    = v.err;
        rready_i     = ~exp_gnt;
        for (int s = 0; s < v.stall; s++) begin
            #1;
            chk("stall_rready", obi_rready_o, 1'b0);
            chk("stall_rvalid", rvalid_o, exp_gnt);
            chk("stall_state", state_o, RESP);
            @(negedge clk_i);
        end
        rready_i = '1;
        #1;
        chk("rready", obi_rready_o, 1'b1);
        chk("rvalid", rvalid_o, exp_gnt);
        chk("rdata", rdata_o, v.rdata);
        chk("err", err_o, v.err);
        @(posedge clk_i);
        #1;
        chk("back_idle", state_o, IDLE);
        chk("idle_rvalid", rvalid_o, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, state_o, IDLE);
        chk({tag, "_gnt"}, gnt_o, '0);
        chk({tag, "_rvalid"}, rvalid_o, '0);
        chk({tag, "_obi_req"}, obi_req_o, 1'b0);
        chk({tag, "_obi_rready"}, obi_rready_o, 1'b0);
        chk({tag, "_obi_addr"}, obi_addr_o, '0);
        chk({tag, "_obi_wdata"}, obi_wdata_o, '0);
        chk({tag, "_rdata"}, rdata_o, '0);
        chk({tag, "_err"}, err_o, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] got;
        int           cyc;
        vec_t         v;

        //          req      gw we  be     wdata         rdata         err st rr fp
        tbl[0]  = '{4'b1111, 0, 1'b0, 4'hF, 32'h1000_0000, 32'h0000_0A00, 1'b0, 0, 0, 0};
        tbl[1]  = '{4'b1111, 1, 1'b0, 4'hF, 32'h1000_0001, 32'h0000_0A01, 1'b0, 1, 1, 0};
        tbl[2]  = '{4'b1111, 0, 1'b0, 4'hF, 32'h1000_0002, 32'h0000_0A02, 1'b0, 0, 2, 0};
        tbl[3]  = '{4'b1111, 2, 1'b0, 4'hF, 32'h1000_0003, 32'h0000_0A03, 1'b0, 0, 3, 0};
        tbl[4]  = '{4'b1111, 0, 1'b0, 4'hF, 32'h1000_0004, 32'h0000_0A04, 1'b0, 0, 0, 0};
        tbl[5]  = '{4'b0001, 2, 1'b0, 4'hF, 32'h1000_0005, 32'hDEAD_BEEF, 1'b0, 0, 0, 0};
        tbl[6]  = '{4'b0101, 0, 1'b0, 4'hF, 32'h1000_0006, 32'h0000_0A06, 1'b0, 1, 2, 0};
        tbl[7]  = '{4'b0101, 1, 1'b0, 4'hF, 32'h1000_0007, 32'h0000_0A07, 1'b0, 0, 0, 0};
        tbl[8]  = '{4'b1000, 0, 1'b0, 4'hF, 32'h1000_0008, 32'h0000_0A08, 1'b0, 0, 3, 3};
        tbl[9]  = '{4'b1010, 0, 1'b0, 4'hF, 32'h1000_0009, 32'h0000_0A09, 1'b0, 0, 1, 1};
        tbl[10] = '{4'b1010, 1, 1'b0, 4'hF, 32'h1000_000A, 32'h0000_0A0A, 1'b0, 0, 3, 1};
        tbl[11] = '{4'b0010, 5, 1'b1, 4'h3, 32'h0000_1234, 32'h0000_0000, 1'b0, 0, 1, 1};
        tbl[12] = '{4'b0001, 0, 1'b0, 4'hF, 32'h1000_000C, 32'h0BAD_0BAD, 1'b1, 3, 0, 0};

        // Reset with requests pending: nothing may leak out.
        reset_ni = 1'b0;
        req_i    = '1;
        clear_bus();
        drive_ports(0, tbl[0]);
        repeat (3) @(negedge clk_i);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        req_i    = '0;
        reset_ni = 1'b1;
        @(negedge clk_i);
        #1;
        chk_all_zero("idle_after_reset");

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i], FIXED ? tbl[i].exp_fp : tbl[i].exp_rr);
        end

        // Reset while port 1 waits in RESP with a response stalled.
        v = tbl[11];
        @(negedge clk_i);
        clear_bus();
        drive_ports(1, v);
        req_i = 4'b0010;
        exp_q.push_back(4'b0010);
        cyc = 0;
        do begin
            @(negedge clk_i);
            #1;
            cyc++;
        end while (!obi_req_o && cyc < 8);
        chk("rst_arb_latency", cyc, 1);
        obi_gnt_i = 1'b1;
        #1;
        got = exp_q.pop_front();
        chk("rst_gnt_o", gnt_o, got);
        @(negedge clk_i);
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'hCAFE_F00D;
        obi_err_i    = 1'b1;
        rready_i     = '0;
        #1;
        chk("rst_pre_state", state_o, RESP);
        chk("rst_pre_rvalid", rvalid_o, 4'b0010);
        @(negedge clk_i);
        reset_ni = 1'b0;
        req_i    = '0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        chk("post_reset_state", state_o, IDLE);
        v.req = 4'b0100;
        v.we  = 1'b0;
        v.be  = 4'hF;
        v.gnt_wait = 1;
        v.rdata = 32'h2222_0002;
        v.err = 1'b0;
        run_txn(v, 2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case the design locks up.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog state=%0h", state_o);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
